// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: fastest-finger-first arbiter for a quiz round.
// Arms on the rising edge of q_active, times the response in ms, grants exactly
// one player by round-robin among simultaneous press edges, locks the rest out,
// and flags a timeout when nobody answers within TIMEOUT_MS.
// Optional feature macro: FALSE_START_PENALTY_EN (players pressing while no
// question is open are locked out of the next question).
`timescale 1ns/1ps

module buzzer_arbiter #(
  parameter int N_PLAYERS    = 3,
  parameter int TICKS_PER_MS = 50000,
  parameter int TIME_W       = 14,
  parameter int TIMEOUT_MS   = 10000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 q_active,
  input  logic [N_PLAYERS-1:0] buzz,
  output logic [N_PLAYERS-1:0] grant,
  output logic                 grant_valid,
  output logic [TIME_W-1:0]    winner_time,
  output logic                 timeout,
  output logic [N_PLAYERS-1:0] lockout
);

  localparam int PTR_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICKS_PER_MS - 1);
  localparam logic [TIME_W-1:0] MS_LIMIT = TIME_W'(TIMEOUT_MS);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(N_PLAYERS - 1);

  typedef enum logic [1:0] {IDLE, ARMED, GRANTED, EXPIRED} state_t;

  state_t state_q, state_d;

  logic [N_PLAYERS-1:0] buzz_q;
  logic                 q_active_q;
  logic [PRE_W-1:0]     prescaler, prescaler_d;
  logic [TIME_W-1:0]    ms_cnt, ms_cnt_d;
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_d;

  logic [N_PLAYERS-1:0] grant_d;
  logic                 grant_valid_d;
  logic [TIME_W-1:0]    winner_time_d;
  logic                 timeout_d;
  logic [N_PLAYERS-1:0] lockout_d;

  logic [N_PLAYERS-1:0] buzz_edge;
  logic [N_PLAYERS-1:0] press;
  logic [N_PLAYERS-1:0] arm_lockout;
  logic                 arm;

  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [N_PLAYERS-1:0] win_onehot;

  // A held button only produces one edge; locked-out players never count as presses.
  assign buzz_edge = buzz & ~buzz_q;
  assign press     = buzz_edge & ~lockout;
  assign arm       = q_active & ~q_active_q;

`ifdef FALSE_START_PENALTY_EN
  logic [N_PLAYERS-1:0] pending;

  // Remember players who jumped the gun while no question was open; hand them over at arm.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else if (state_q == IDLE) begin
      if (arm) begin
        pending <= '0;
      end else if (!q_active) begin
        pending <= pending | buzz_edge;
      end
    end
  end

  assign arm_lockout = pending;
`else
  assign arm_lockout = '0;
`endif

  // Round-robin pick: first pressing player at or above rr_ptr, else the first below it.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (!win_found && press[i] && (i >= int'(rr_ptr))) begin
        win_found     = 1'b1;
        win_idx       = PTR_W'(i);
        win_onehot[i] = 1'b1;
      end
    end
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (!win_found && press[i] && (i < int'(rr_ptr))) begin
        win_found     = 1'b1;
        win_idx       = PTR_W'(i);
        win_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; everything holds unless a transition changes it.
  always_comb begin
    state_d       = state_q;
    prescaler_d   = prescaler;
    ms_cnt_d      = ms_cnt;
    rr_ptr_d      = rr_ptr;
    grant_d       = grant;
    grant_valid_d = grant_valid;
    winner_time_d = winner_time;
    timeout_d     = timeout;
    lockout_d     = lockout;

    if (!q_active) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            grant_d       = '0;
            grant_valid_d = 1'b0;
            timeout_d     = 1'b0;
            winner_time_d = '0;
            prescaler_d   = '0;
            ms_cnt_d      = '0;
            lockout_d     = arm_lockout;
            state_d       = ARMED;
          end
        end
        ARMED: begin
          if (prescaler == PRE_LAST) begin
            prescaler_d = '0;
            if (ms_cnt != MS_LIMIT) begin
              ms_cnt_d = ms_cnt + TIME_W'(1);
            end
          end else begin
            prescaler_d = prescaler + PRE_W'(1);
          end

          if (win_found) begin
            grant_d       = win_onehot;
            grant_valid_d = 1'b1;
            winner_time_d = ms_cnt;
            lockout_d     = ~win_onehot;
            rr_ptr_d      = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);
            state_d       = GRANTED;
          end else if (ms_cnt == MS_LIMIT) begin
            timeout_d = 1'b1;
            lockout_d = '1;
            state_d   = EXPIRED;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State, counters and outputs register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      prescaler   <= '0;
      ms_cnt      <= '0;
      rr_ptr      <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      winner_time <= '0;
      timeout     <= 1'b0;
      lockout     <= '0;
    end else begin
      state_q     <= state_d;
      prescaler   <= prescaler_d;
      ms_cnt      <= ms_cnt_d;
      rr_ptr      <= rr_ptr_d;
      grant       <= grant_d;
      grant_valid <= grant_valid_d;
      winner_time <= winner_time_d;
      timeout     <= timeout_d;
      lockout     <= lockout_d;
    end
  end

  // Previous-cycle copies of the buttons and q_active for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      buzz_q     <= '0;
      q_active_q <= 1'b0;
    end else begin
      buzz_q     <= buzz;
      q_active_q <= q_active;
    end
  end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb_buzzer_arbiter: directed bench for buzzer_arbiter with a 4-cycle ms and 5 ms timeout.
`timescale 1ns/1ps

module tb_buzzer_arbiter;

  logic        clk;
  logic        reset;
  logic        q_active;
  logic [2:0]  buzz;
  logic [2:0]  grant;
  logic        grant_valid;
  logic [13:0] winner_time;
  logic        timeout;
  logic [2:0]  lockout;

  int checks;
  int errors;

  buzzer_arbiter #(
    .N_PLAYERS   (3),
    .TICKS_PER_MS(4),
    .TIME_W      (14),
    .TIMEOUT_MS  (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .q_active   (q_active),
    .buzz       (buzz),
    .grant      (grant),
    .grant_valid(grant_valid),
    .winner_time(winner_time),
    .timeout    (timeout),
    .lockout    (lockout)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic q, input logic [2:0] b);
    q_active = q;
    buzz     = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] g, input logic gv,
                          input logic [13:0] wt, input logic to, input logic [2:0] lo);
    checkOutput({tag, ".grant"}, 32'(grant), 32'(g));
    checkOutput({tag, ".grant_valid"}, 32'(grant_valid), 32'(gv));
    checkOutput({tag, ".winner_time"}, 32'(winner_time), 32'(wt));
    checkOutput({tag, ".timeout"}, 32'(timeout), 32'(to));
    checkOutput({tag, ".lockout"}, 32'(lockout), 32'(lo));
  endtask

  // Drop q_active long enough to reach IDLE, then raise it; the next edge arms.
  task automatic armQuestion(input logic [2:0] b);
    applyStimulus(1'b0, 3'b000);
    tick(2);
    applyStimulus(1'b1, b);
  endtask

  // Single press pulse: edge sampled at the next posedge, visible at the following negedge.
  task automatic pulse(input logic [2:0] b);
    buzz = b;
    tick(1);
    buzz = 3'b000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    applyStimulus(1'b0, 3'b000);
    tick(2);
    checkAll("reset", 3'b000, 1'b0, 14'd0, 1'b0, 3'b000);
    reset = 1'b0;
    tick(1);

    $display("[TB] single press at ms 2");
    armQuestion(3'b000);
    tick(9);
    checkOutput("t1.no_grant_yet", 32'(grant_valid), 32'd0);
    pulse(3'b010);
    checkAll("t1", 3'b010, 1'b1, 14'd2, 1'b0, 3'b101);
    tick(1);
    pulse(3'b001);
    tick(1);
    checkOutput("t1.late_press", 32'(grant), 32'(3'b010));
    q_active = 1'b0;
    tick(1);
    checkOutput("t1.idle_hold", 32'(grant), 32'(3'b010));

    $display("[TB] round-robin on simultaneous presses");
    armQuestion(3'b000);
    tick(2);
    pulse(3'b101);
    checkAll("rr_ptr2", 3'b100, 1'b1, 14'd0, 1'b0, 3'b011);
    armQuestion(3'b000);
    tick(2);
    pulse(3'b101);
    checkAll("rr_ptr0", 3'b001, 1'b1, 14'd0, 1'b0, 3'b110);
    armQuestion(3'b000);
    tick(2);
    pulse(3'b101);
    checkAll("rr_ptr1", 3'b100, 1'b1, 14'd0, 1'b0, 3'b011);

    $display("[TB] press wins on the timeout cycle");
    armQuestion(3'b000);
    tick(21);
    pulse(3'b010);
    checkAll("press_vs_timeout", 3'b010, 1'b1, 14'd5, 1'b0, 3'b101);

    $display("[TB] unanswered question times out");
    armQuestion(3'b000);
    tick(21);
    checkOutput("t3.before_timeout", 32'(timeout), 32'd0);
    tick(1);
    checkAll("t3", 3'b000, 1'b0, 14'd0, 1'b1, 3'b111);
    tick(1);
    pulse(3'b010);
    tick(1);
    checkOutput("t3.late_press", 32'(grant), 32'(3'b000));

    $display("[TB] button held across arm");
    armQuestion(3'b001);
    tick(5);
    buzz = 3'b000;
    tick(8);
    checkOutput("t4.held_no_grant", 32'(grant_valid), 32'd0);
    pulse(3'b001);
    checkAll("t4", 3'b001, 1'b1, 14'd3, 1'b0, 3'b110);

    $display("[TB] reset while granted");
    reset    = 1'b1;
    q_active = 1'b0;
    tick(1);
    reset = 1'b0;
    checkAll("t5.reset", 3'b000, 1'b0, 14'd0, 1'b0, 3'b000);
    tick(1);
    armQuestion(3'b000);
    tick(2);
    pulse(3'b011);
    checkAll("t5.after", 3'b001, 1'b1, 14'd0, 1'b0, 3'b110);

    $display("[TB] one-cycle q_active glitch re-arms");
    q_active = 1'b0;
    tick(1);
    q_active = 1'b1;
    tick(1);
    checkOutput("rearm.cleared", 32'(grant_valid), 32'd0);
    pulse(3'b100);
    checkAll("rearm", 3'b100, 1'b1, 14'd0, 1'b0, 3'b011);

    $display("[TB] press while no question is open");
    applyStimulus(1'b0, 3'b000);
    tick(2);
    pulse(3'b100);
    tick(1);
    q_active = 1'b1;
    tick(1);
`ifdef FALSE_START_PENALTY_EN
    checkAll("t6.arm", 3'b000, 1'b0, 14'd0, 1'b0, 3'b100);
    pulse(3'b100);
    tick(1);
    checkOutput("t6.penalised", 32'(grant_valid), 32'd0);
    pulse(3'b010);
    checkAll("t6.other", 3'b010, 1'b1, 14'd0, 1'b0, 3'b101);
`else
    checkAll("t6.arm", 3'b000, 1'b0, 14'd0, 1'b0, 3'b000);
    pulse(3'b100);
    checkAll("t6.wins", 3'b100, 1'b1, 14'd0, 1'b0, 3'b011);
    tick(1);
    pulse(3'b010);
    tick(1);
    checkOutput("t6.locked", 32'(grant), 32'(3'b100));
`endif

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
